seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a 4-digit common-anode
// seven-segment display. One shared BCD decoder is fed one nibble at a time.
// Each digit gets a SHOW slot followed by an all-off guard GAP. The display
// value is double-buffered and commits only at frame boundaries.
//
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN
//   defined   -> leading zero digits (never digit 0) are blanked
//   undefined -> every valid nibble is displayed
//
// Output timing: every output is registered from the current scan position,
// so the visible outputs trail the internal slot counter by one clock.
module seg7_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned CNT_W       = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic        load,
  output logic        pending,
  output logic [3:0]  bcd_out,
  output logic [3:0]  an,
  output logic [1:0]  digit_sel,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] ShowLast = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit               HasGap   = (GAP_CYCLES > 0);

  typedef enum logic [0:0] {
    StShow,
    StGap
  } state_e;

  // Scan sequencer state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;

  // Double buffer
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      active_q, active_d;
  logic             pending_q, pending_d;
  logic             commit;

  // Registered outputs
  logic [3:0]       an_q, an_d;
  logic [3:0]       bcd_q, bcd_d;
  logic [1:0]       dsel_q, dsel_d;
  logic             fd_q, fd_d;

  // Digit decode helpers
  logic [3:0]       nibble;
  logic [3:0]       blank;
  logic             digit_off;
  logic             advance;

  // Shadow/active buffer update; commit happens on the clock that ends the
  // frame_done cycle, so a load in that same cycle lands in the next frame.
  always_comb begin
    commit    = fd_q & pending_q;
    active_d  = commit ? shadow_q : active_q;
    shadow_d  = load ? value_in : shadow_q;
    pending_d = load | (pending_q & ~commit);
  end

  // Nibble selection and per-digit blanking. active_d is used so digit 0 of
  // a freshly committed frame already shows the new value.
  always_comb begin
    nibble = active_d[{sel_q, 2'b00} +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    blank[3] = (active_d[15:12] == 4'd0);
    blank[2] = blank[3] & (active_d[11:8] == 4'd0);
    blank[1] = blank[2] & (active_d[7:4] == 4'd0);
    blank[0] = 1'b0;
`else
    blank = 4'b0000;
`endif
    digit_off = (nibble > 4'd9) | blank[sel_q];
  end

  // Next-state and next-output logic for the SHOW/GAP scan sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    an_d    = 4'b1111;
    bcd_d   = bcd_q;
    dsel_d  = sel_q;
    fd_d    = 1'b0;
    advance = 1'b0;

    if (!enable) begin
      // Blank and park at the start of a frame
      state_d = StShow;
      cnt_d   = '0;
      sel_d   = 2'd0;
      dsel_d  = 2'd0;
    end else begin
      unique case (state_q)
        StShow: begin
          an_d  = digit_off ? 4'b1111 : ~(4'b0001 << sel_q);
          bcd_d = nibble;
          if (cnt_q == ShowLast) begin
            cnt_d = '0;
            if (HasGap) begin
              state_d = StGap;
            end else begin
              advance = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            advance = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase

      if (advance) begin
        state_d = StShow;
        cnt_d   = '0;
        sel_d   = sel_q + 2'd1;
        fd_d    = (sel_q == 2'd3);
      end
    end
  end

  // State, buffer and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StShow;
      cnt_q     <= '0;
      sel_q     <= 2'd0;
      shadow_q  <= 16'h0000;
      active_q  <= 16'h0000;
      pending_q <= 1'b0;
      an_q      <= 4'b1111;
      bcd_q     <= 4'd0;
      dsel_q    <= 2'd0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      bcd_q     <= bcd_d;
      dsel_q    <= dsel_d;
      fd_q      <= fd_d;
    end
  end

  assign pending    = pending_q;
  assign bcd_out    = bcd_q;
  assign an         = an_q;
  assign digit_sel  = dsel_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with REFRESH_DIV=4, GAP_CYCLES=1 (20-cycle frame).
// A frame-position reference model predicts every output per clock; results
// go through a scoreboard queue. Table phases plus hand-written corner cases.
module tb_seg7_scan_ctrl;

  localparam int unsigned RefreshDiv = 4;
  localparam int unsigned GapCycles  = 1;
  localparam int          Slot       = RefreshDiv + GapCycles;
  localparam int          Frame      = 4 * Slot;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] value_in;
  logic        load;
  logic        pending;
  logic [3:0]  bcd_out;
  logic [3:0]  an;
  logic [1:0]  digit_sel;
  logic        frame_done;

  seg7_scan_ctrl #(
    .REFRESH_DIV (RefreshDiv),
    .GAP_CYCLES  (GapCycles),
    .CNT_W       (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .value_in   (value_in),
    .load       (load),
    .pending    (pending),
    .bcd_out    (bcd_out),
    .an         (an),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] bcd;
    logic [1:0] sel;
    logic       fd;
    logic       pend;
  } exp_t;

  typedef struct {
    string       name;
    logic        en;
    logic        ld;
    logic [15:0] val;
    int          n;
    int          exp_fd;
    logic        exp_pend;
  } phase_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   fd_seen = 0;

  // Reference model state
  logic [15:0] m_shadow = 16'h0;
  logic [15:0] m_active = 16'h0;
  logic        m_pend   = 1'b0;
  logic        m_fd     = 1'b0;
  logic [3:0]  m_bcd    = 4'h0;
  int          m_run    = 0;

  function automatic logic lz_blank(input logic [15:0] v, input int d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    return (d > 0) && ((v >> (4 * d)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Drive one clock of stimulus, predict the post-edge outputs, compare.
  task automatic step(input string name, input logic r, input logic e, input logic l,
                      input logic [15:0] v);
    exp_t x;
    exp_t y;
    exp_t got;
    logic commit;
    int   p;
    int   d;
    logic [3:0] nib;
    reset    = r;
    enable   = e;
    load     = l;
    value_in = v;
    if (r) begin
      m_shadow = 16'h0;
      m_active = 16'h0;
      m_pend   = 1'b0;
      m_run    = 0;
      x        = '{an: 4'hF, bcd: 4'h0, sel: 2'd0, fd: 1'b0, pend: 1'b0};
    end else begin
      commit = m_fd & m_pend;
      if (commit) m_active = m_shadow;
      m_pend = l | (m_pend & ~commit);
      if (l) m_shadow = v;
      x.pend = m_pend;
      if (!e) begin
        m_run = 0;
        x.an  = 4'hF;
        x.bcd = m_bcd;
        x.sel = 2'd0;
        x.fd  = 1'b0;
      end else begin
        p = m_run % Frame;
        d = p / Slot;
        m_run++;
        x.sel = 2'(d);
        x.fd  = (p == Frame - 1);
        if ((p % Slot) < RefreshDiv) begin
          nib   = 4'((m_active >> (4 * d)) & 16'hF);
          x.bcd = nib;
          x.an  = (nib > 4'd9 || lz_blank(m_active, d)) ? 4'hF : ~(4'b0001 << d);
        end else begin
          x.an  = 4'hF;
          x.bcd = m_bcd;
        end
      end
    end
    m_fd  = x.fd;
    m_bcd = x.bcd;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    got = '{an: an, bcd: bcd_out, sel: digit_sel, fd: frame_done, pend: pending};
    if (frame_done === 1'b1) fd_seen++;
    y = exp_q.pop_front();
    total++;
    if (got !== y) begin
      bad++;
      $display("FAIL %s: got an=%b bcd=%h sel=%0d fd=%b pend=%b want an=%b bcd=%h sel=%0d fd=%b pend=%b",
               name, got.an, got.bcd, got.sel, got.fd, got.pend,
               y.an, y.bcd, y.sel, y.fd, y.pend);
    end
  endtask

  phase_t tbl[7];

  initial begin
    tbl[0] = '{"idle_frames", 1'b1, 1'b0, 16'h0000, 40, 2, 1'b0};
    tbl[1] = '{"pre_load",    1'b1, 1'b0, 16'h0000,  7, 0, 1'b0};
    tbl[2] = '{"load_1234",   1'b1, 1'b1, 16'h1234, 33, 2, 1'b0};
    tbl[3] = '{"load_5678",   1'b1, 1'b1, 16'h5678,  5, 0, 1'b1};
    tbl[4] = '{"load_9012",   1'b1, 1'b1, 16'h9012,  5, 0, 1'b1};
    tbl[5] = '{"run_9012",    1'b1, 1'b0, 16'h0000, 30, 2, 1'b0};
    tbl[6] = '{"load_12a4",   1'b1, 1'b1, 16'h12A4, 40, 2, 1'b0};

    reset = 1'b1; enable = 1'b0; load = 1'b0; value_in = 16'h0;
    for (int i = 0; i < 3; i++) step("reset", 1'b1, 1'b0, 1'b0, 16'h0);

    // Table phases: load (if any) on the first cycle, then hold
    for (int t = 0; t < 7; t++) begin
      fd_seen = 0;
      for (int c = 0; c < tbl[t].n; c++)
        step(tbl[t].name, 1'b0, tbl[t].en, tbl[t].ld && (c == 0), tbl[t].val);
      check({tbl[t].name, "_fd_count"}, 16'(fd_seen), 16'(tbl[t].exp_fd));
      check({tbl[t].name, "_pending"}, {15'd0, pending}, {15'd0, tbl[t].exp_pend});
    end

    // Load landing on the commit clock: earlier value commits, pending stays
    step("lc_load1", 1'b0, 1'b1, 1'b1, 16'h1111);
    for (int c = 0; c < 18; c++) step("lc_run", 1'b0, 1'b1, 1'b0, 16'h0);
    step("lc_fd", 1'b0, 1'b1, 1'b0, 16'h0);
    check("lc_fd_high", {15'd0, frame_done}, 16'd1);
    step("lc_load2", 1'b0, 1'b1, 1'b1, 16'h2222);
    check("lc_pend_kept", {15'd0, pending}, 16'd1);
    check("lc_bcd_old", {12'd0, bcd_out}, 16'd1);
    for (int c = 0; c < 20; c++) step("lc_next", 1'b0, 1'b1, 1'b0, 16'h0);
    check("lc_bcd_new", {12'd0, bcd_out}, 16'd2);
    check("lc_pend_clr", {15'd0, pending}, 16'd0);

    // Enable dropped in digit 2, load while disabled, then re-enable
    for (int c = 0; c < 11; c++) step("en_pre", 1'b0, 1'b1, 1'b0, 16'h0);
    check("en_digit2", {12'd0, an}, 16'b1011);
    fd_seen = 0;
    step("en_off", 1'b0, 1'b0, 1'b1, 16'h3333);
    check("en_off_an", {12'd0, an}, 16'hF);
    check("en_off_sel", {14'd0, digit_sel}, 16'd0);
    for (int c = 0; c < 24; c++) step("en_off_hold", 1'b0, 1'b0, 1'b0, 16'h0);
    check("en_off_fd_count", 16'(fd_seen), 16'd0);
    check("en_off_pend", {15'd0, pending}, 16'd1);
    step("en_on", 1'b0, 1'b1, 1'b0, 16'h0);
    check("en_on_an", {12'd0, an}, 16'b1110);
    check("en_on_bcd", {12'd0, bcd_out}, 16'd2);
    for (int c = 0; c < 20; c++) step("en_on_run", 1'b0, 1'b1, 1'b0, 16'h0);
    check("en_commit_bcd", {12'd0, bcd_out}, 16'd3);

    // Reset mid-frame with a pending value
    step("rst_load", 1'b0, 1'b1, 1'b1, 16'h4444);
    step("rst_pre", 1'b0, 1'b1, 1'b0, 16'h0);
    step("rst_pre", 1'b0, 1'b1, 1'b0, 16'h0);
    step("rst_mid", 1'b1, 1'b1, 1'b0, 16'h0);
    check("rst_pend", {15'd0, pending}, 16'd0);
    check("rst_an", {12'd0, an}, 16'hF);
    step("rst_mid", 1'b1, 1'b1, 1'b0, 16'h0);
    step("rst_rel", 1'b0, 1'b1, 1'b0, 16'h0);
    check("rst_rel_an", {12'd0, an}, 16'b1110);
    check("rst_rel_bcd", {12'd0, bcd_out}, 16'd0);

    // Leading zeros: 0070 then 0000
    step("lz_load", 1'b0, 1'b1, 1'b1, 16'h0070);
    for (int c = 0; c < 19; c++) step("lz_run", 1'b0, 1'b1, 1'b0, 16'h0);
    check("lz_d0_an", {12'd0, an}, 16'b1110);
    for (int c = 0; c < 5; c++) step("lz_run", 1'b0, 1'b1, 1'b0, 16'h0);
    check("lz_d1_an", {12'd0, an}, 16'b1101);
    check("lz_d1_bcd", {12'd0, bcd_out}, 16'd7);
    for (int c = 0; c < 5; c++) step("lz_run", 1'b0, 1'b1, 1'b0, 16'h0);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    check("lz_d2_an", {12'd0, an}, 16'b1111);
`else
    check("lz_d2_an", {12'd0, an}, 16'b1011);
`endif
    step("lz_load0", 1'b0, 1'b1, 1'b1, 16'h0000);
    for (int c = 0; c < 40; c++) step("lz_zero", 1'b0, 1'b1, 1'b0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
